// File: rtl/mul_round_sat.sv
// Post-multiplier stage: arms the Booth multiplier, captures its signed product,
// drops FRAC fractional bits and saturates to OUT_LEN bits. `ROUND_NEAREST_EN selects round-half-up.
module mul_round_sat #(
    parameter int IN_LEN  = 64,
    parameter int FRAC    = 16,
    parameter int OUT_LEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    output logic               fin,
    output logic [OUT_LEN-1:0] out,
    output logic               sat,
    output logic               mul_arm,
    input  logic               mul_fin,
    input  logic [IN_LEN-1:0]  mul_outn
);

    localparam int SHR_W = IN_LEN + 1 - FRAC;

    // Output range limits sign-extended to the shifted width for a signed compare.
    localparam logic signed [SHR_W-1:0] SAT_MAX = {{(SHR_W-OUT_LEN+1){1'b0}}, {(OUT_LEN-1){1'b1}}};
    localparam logic signed [SHR_W-1:0] SAT_MIN = {{(SHR_W-OUT_LEN+1){1'b1}}, {(OUT_LEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ROUND,
        S_SAT,
        S_DONE
    } state_t;

    state_t                     state_reg, state_next;
    logic [IN_LEN-1:0]          prod_reg;
    logic signed [SHR_W-1:0]    shr_reg, shr_next;
    logic [OUT_LEN-1:0]         out_reg, out_next;
    logic                       sat_reg, sat_next;
    logic [IN_LEN:0]            sum_ext;
    logic                       prod_load, shr_load, res_load;
    logic                       frac_unused;

    // Extra top bit keeps +max products from wrapping when the rounding constant is added.
`ifdef ROUND_NEAREST_EN
    localparam logic [IN_LEN:0] RC_VAL = {{IN_LEN{1'b0}}, 1'b1} << (FRAC - 1);
    assign sum_ext = {prod_reg[IN_LEN-1], prod_reg} + RC_VAL;
`else
    assign sum_ext = {prod_reg[IN_LEN-1], prod_reg};
`endif

    assign shr_next    = sum_ext[IN_LEN:FRAC];
    assign frac_unused = ^sum_ext[FRAC-1:0];

    always_comb begin
        out_next = shr_reg[OUT_LEN-1:0];
        sat_next = 1'b0;
        if (shr_reg > SAT_MAX) begin
            out_next = {1'b0, {(OUT_LEN-1){1'b1}}};
            sat_next = 1'b1;
        end else if (shr_reg < SAT_MIN) begin
            out_next = {1'b1, {(OUT_LEN-1){1'b0}}};
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            out_reg   <= '0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (res_load) begin
                out_reg <= out_next;
                sat_reg <= sat_next;
            end
        end
    end

    // Datapath pipeline registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (prod_load) begin
            prod_reg <= mul_outn;
        end
        if (shr_load) begin
            shr_reg <= shr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        prod_load  = 1'b0;
        shr_load   = 1'b0;
        res_load   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (arm) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!arm) begin
                    state_next = S_IDLE;
                end else if (mul_fin) begin
                    prod_load  = 1'b1;
                    state_next = S_ROUND;
                end
            end
            S_ROUND: begin
                if (!arm) begin
                    state_next = S_IDLE;
                end else begin
                    shr_load   = 1'b1;
                    state_next = S_SAT;
                end
            end
            S_SAT: begin
                if (!arm) begin
                    state_next = S_IDLE;
                end else begin
                    res_load   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!arm) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Multiplier stays armed through DONE so its product remains stable.
    assign mul_arm = (state_reg != S_IDLE);
    assign fin     = (state_reg == S_DONE);
    assign out     = out_reg;
    assign sat     = sat_reg;

endmodule

// File: tb/tb_mul_round_sat.sv
// Bench for mul_round_sat: multiplier stand-in with configurable fin delay,
// per-cycle comparison against an arithmetic reference model, plus directed literals.
module tb_mul_round_sat;

`ifdef ROUND_NEAREST_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        arm;
    logic        fin;
    logic [31:0] out;
    logic        sat;
    logic        mul_arm;
    logic        mul_fin;
    logic [63:0] mul_outn;

    int          tests = 0;
    int          fails = 0;

    logic [63:0] cur_prod  = '0;
    int          fin_delay = 1;
    int          mcnt      = 0;

    int          cyc       = 0;
    logic        m_arm     = 1'b0;
    logic        m_fin     = 1'b0;
    logic [31:0] m_out     = '0;
    logic        m_sat     = 1'b0;
    logic        cap_valid = 1'b0;
    logic [63:0] cap_prod  = '0;
    int          cap_cyc   = 0;

    mul_round_sat #(.IN_LEN(64), .FRAC(16), .OUT_LEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .fin      (fin),
        .out      (out),
        .sat      (sat),
        .mul_arm  (mul_arm),
        .mul_fin  (mul_fin),
        .mul_outn (mul_outn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: exact wide arithmetic, floor division by 2^16, then clip to int32.
    function automatic logic [32:0] ref_result(input logic [63:0] p);
        logic signed [127:0] wide;
        longint              q;
        wide = {{64{p[63]}}, p};
        if (RND) wide = wide + 128'sd32768;
        wide = wide >>> 16;
        q = $signed(wide[63:0]);
        if (q > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
        if (q < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, q[31:0]};
    endfunction

    // Multiplier stand-in: fin rises fin_delay cycles after arm, product valid only with fin.
    always @(negedge clk) begin
        if (!mul_arm) begin
            mcnt    = 0;
            mul_fin = 1'b0;
        end else begin
            mcnt++;
            if (mcnt >= fin_delay) mul_fin = 1'b1;
        end
        mul_outn = mul_fin ? cur_prod : 64'hA5A5_5A5A_C3C3_3C3C;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs: mul_arm follows arm by one edge; a result appears two edges after capture.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_arm     <= 1'b0;
            m_fin     <= 1'b0;
            m_out     <= '0;
            m_sat     <= 1'b0;
            cap_valid <= 1'b0;
        end else begin
            m_arm <= arm;
            if (!arm) begin
                cap_valid <= 1'b0;
                m_fin     <= 1'b0;
            end else if (!cap_valid && m_arm && mul_fin) begin
                cap_valid <= 1'b1;
                cap_prod  <= mul_outn;
                cap_cyc   <= cyc;
            end else if (cap_valid && !m_fin && cyc == cap_cyc + 2) begin
                m_fin <= 1'b1;
                {m_sat, m_out} <= ref_result(cap_prod);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_fin", {63'd0, fin}, {63'd0, m_fin});
        chk("cyc_mul_arm", {63'd0, mul_arm}, {63'd0, m_arm});
        chk("cyc_out", {32'd0, out}, {32'd0, m_out});
        chk("cyc_sat", {63'd0, sat}, {63'd0, m_sat});
    end

    task automatic run_op(input logic [63:0] prod, input int dly, input logic [31:0] lit_out,
                          input logic lit_sat, input string nm, input bit drop);
        int n;
        cur_prod  = prod;
        fin_delay = dly;
        arm       = 1'b1;
        n         = 0;
        @(negedge clk);
        while (!fin && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!fin) begin
            fails++;
            tests++;
            $display("FAIL %s_timeout: fin still 0 after %0d cycles, required 1", nm, n);
        end else begin
            chk({nm, "_out"}, {32'd0, out}, {32'd0, lit_out});
            chk({nm, "_sat"}, {63'd0, sat}, {63'd0, lit_sat});
            chk({nm, "_lat"}, 64'((cyc - 1) - cap_cyc), 64'd2);
        end
        $display("[TB] op %s prod=%h delay=%0d out=%h sat=%0d", nm, prod, dly, out, sat);
        if (drop) begin
            arm = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst      = 1'b1;
        arm      = 1'b0;
        mul_fin  = 1'b0;
        mul_outn = '0;
        repeat (2) @(negedge clk);
        chk("rst_fin", {63'd0, fin}, 64'd0);
        chk("rst_out", {32'd0, out}, 64'd0);
        chk("rst_mul_arm", {63'd0, mul_arm}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(64'h0000_0000_0003_8000, 1, RND ? 32'd4 : 32'd3, 1'b0, "pos3p5", 1'b1);
        run_op(64'hFFFF_FFFF_FFFE_8000, 3, RND ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, 1'b0, "neg1p5", 1'b1);
        run_op(64'h0000_8000_0000_0000, 2, 32'h7FFF_FFFF, 1'b1, "pos_sat", 1'b1);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 1, 32'h7FFF_FFFF, 1'b1, "pos_max", 1'b1);
        run_op(64'h0000_7FFF_FFFF_8000, 2, 32'h7FFF_FFFF, RND, "pos_edge", 1'b1);
        run_op(64'hFFFF_0000_0000_0000, 4, 32'h8000_0000, 1'b1, "neg_sat", 1'b1);
        run_op(64'hFFFF_8000_0000_0000, 1, 32'h8000_0000, 1'b0, "neg_min", 1'b1);
        run_op(64'hFFFF_FFFF_8000_0000, 2, 32'hFFFF_8000, 1'b0, "neg_small", 1'b1);

        // Abort while waiting for the multiplier.
        cur_prod  = 64'h0000_0000_0009_0000;
        fin_delay = 6;
        arm       = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_armed", {63'd0, mul_arm}, 64'd1);
        arm = 1'b0;
        @(negedge clk);
        chk("abort_mul_arm", {63'd0, mul_arm}, 64'd0);
        chk("abort_out", {32'd0, out}, 64'h0000_0000_FFFF_8000);
        chk("abort_sat", {63'd0, sat}, 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_fin", {63'd0, fin}, 64'd0);
        $display("[TB] op abort out=%h sat=%0d fin=%0d", out, sat, fin);
        run_op(64'h0000_0000_0005_0000, 2, 32'd5, 1'b0, "rearm", 1'b1);

        // Asynchronous reset while DONE.
        run_op(64'h0000_8000_0000_0000, 1, 32'h7FFF_FFFF, 1'b1, "pre_rst", 1'b0);
        #2;
        rst = 1'b1;
        arm = 1'b0;
        #1;
        chk("arst_fin", {63'd0, fin}, 64'd0);
        chk("arst_out", {32'd0, out}, 64'd0);
        chk("arst_sat", {63'd0, sat}, 64'd0);
        chk("arst_mul_arm", {63'd0, mul_arm}, 64'd0);
        $display("[TB] op async_reset fin=%0d out=%h sat=%0d mul_arm=%0d", fin, out, sat, mul_arm);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(64'h0000_0000_0001_0000, 1, 32'd1, 1'b0, "post_rst", 1'b1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule
